div_iter: RTL

Parametrised iterative radix-2 integer divider for the MIPS pipeline's HI/LO unit. It generalises the fixed 32-bit divider to any even `WIDTH` and replaces start/ready levels with valid/ready handshakes on both sides. Operands are latched at accept, and divide-by-zero and signed-overflow results are defined and flagged. It sits beside the multiplier in EX and writes quotient to LO and remainder to HI.

---
 rtl/div_iter_pkg.sv | 19 +
 rtl/div_iter_if.sv | 27 ++
 rtl/div_iter_clz.sv | 28 ++
 rtl/div_iter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding, default width
// and the width of the step counter.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } div_state_e;

    localparam int unsigned DIV_W_DEFAULT = 32;

    // The counter must be able to hold WIDTH itself, not just WIDTH-1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_iter_if.sv
// Request/response bundle of the divider: operand handshake, flush and result handshake.
interface div_iter_if #(
    parameter int unsigned WIDTH = div_pkg::DIV_W_DEFAULT
);
    logic             in_valid;
    logic             in_ready;
    logic             is_signed;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             cancel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output in_valid, is_signed, operand1, operand2, cancel, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, is_signed, operand1, operand2, cancel, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div_iter_clz.sv
// Combinational leading-zero count; an all-zero input yields WIDTH.
module div_clz
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_W_DEFAULT
) (
    input  logic [WIDTH-1:0]             value,
    output logic [cnt_width(WIDTH)-1:0]  count
);
    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic found;

    always_comb begin
        count = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!found) begin
                if (value[WIDTH-1-i]) begin
                    found = 1'b1;
                end else begin
                    count = count + CNT_ONE;
                end
            end
        end
    end
endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider with valid/ready handshakes, flush, and flagged
// divide-by-zero / signed-overflow results. Define DIV_EARLY_OUT_EN to skip leading zeros.
module div_iter
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_W_DEFAULT
) (
    input logic       clk,
    input logic       rst,
    div_iter_if.slave bus
);
    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] LSB_ONE  = WIDTH'(1);

    div_state_e state, state_next;

    logic [CW-1:0]    count;
    logic [2*WIDTH:0] part;
    logic [WIDTH-1:0] divisor;
    logic             sign_a;
    logic             sign_b;
    logic             mode_signed;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;
    logic             dbz_res;
    logic             ovf_res;

    logic             accept;
    logic             take_zero;
    logic             take_ovf;
    logic             skip_calc;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] start_low;
    logic [CW-1:0]    start_count;
    logic [2*WIDTH:0] shifted;
    logic [2*WIDTH:0] part_step;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    always_comb begin
        accept    = bus.in_valid && (state == ST_IDLE) && !rst && !bus.cancel;
        take_zero = (bus.operand2 == '0);
        take_ovf  = bus.is_signed && (bus.operand1 == MIN_VAL) && (bus.operand2 == '1);
        mag_a     = (bus.is_signed && bus.operand1[WIDTH-1]) ? -bus.operand1 : bus.operand1;
        mag_b     = (bus.is_signed && bus.operand2[WIDTH-1]) ? -bus.operand2 : bus.operand2;
    end

`ifdef DIV_EARLY_OUT_EN
    logic [CW-1:0] lead;

    div_clz #(.WIDTH(WIDTH)) u_clz (
        .value (mag_a),
        .count (lead)
    );

    // Leading zeros of the dividend only produce zero quotient bits, so they are
    // consumed up front by pre-shifting and starting the counter at their count.
    always_comb begin
        start_low   = mag_a << lead;
        start_count = lead;
        skip_calc   = (lead == CNT_LAST);
    end
`else
    always_comb begin
        start_low   = mag_a;
        start_count = '0;
        skip_calc   = 1'b0;
    end
`endif

    // The upper half stays below 2*divisor, so bit WIDTH of the trial is its sign.
    always_comb begin
        shifted   = part << 1;
        trial     = shifted[2*WIDTH:WIDTH] - {1'b0, divisor};
        part_step = shifted;
        if (!trial[WIDTH]) begin
            part_step = {trial, shifted[WIDTH-1:0] | LSB_ONE};
        end
        q_fix = part[WIDTH-1:0];
        r_fix = part[2*WIDTH-1:WIDTH];
        if (mode_signed && (sign_a ^ sign_b)) begin
            q_fix = -part[WIDTH-1:0];
        end
        if (mode_signed && sign_a) begin
            r_fix = -part[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (take_zero || take_ovf) begin
                        state_next = ST_DONE;
                    end else if (skip_calc) begin
                        state_next = ST_FIX;
                    end else begin
                        state_next = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (bus.cancel) begin
                    state_next = ST_IDLE;
                end else if (count + CNT_ONE == CNT_LAST) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                state_next = bus.cancel ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                if (bus.cancel || bus.out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            part        <= '0;
            divisor     <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            mode_signed <= 1'b0;
            q_res       <= '0;
            r_res       <= '0;
            dbz_res     <= 1'b0;
            ovf_res     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mode_signed <= bus.is_signed;
                        sign_a      <= bus.is_signed && bus.operand1[WIDTH-1];
                        sign_b      <= bus.is_signed && bus.operand2[WIDTH-1];
                        divisor     <= mag_b;
                        part        <= {{(WIDTH+1){1'b0}}, start_low};
                        count       <= start_count;
                        if (take_zero) begin
                            q_res   <= '1;
                            r_res   <= bus.operand1;
                            dbz_res <= 1'b1;
                        end else if (take_ovf) begin
                            q_res   <= bus.operand1;
                            r_res   <= '0;
                            ovf_res <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    part  <= part_step;
                    count <= count + CNT_ONE;
                end
                ST_FIX: begin
                    if (!bus.cancel) begin
                        q_res <= q_fix;
                        r_res <= r_fix;
                    end
                end
                ST_DONE: begin
                    if (bus.cancel || bus.out_ready) begin
                        q_res   <= '0;
                        r_res   <= '0;
                        dbz_res <= 1'b0;
                        ovf_res <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.in_ready    = (state == ST_IDLE) && !rst;
        bus.out_valid   = (state == ST_DONE);
        bus.quotient    = q_res;
        bus.remainder   = r_res;
        bus.div_by_zero = dbz_res;
        bus.overflow    = ovf_res;
    end
endmodule
